se_target_select: RTL and testbench

- Per-pixel front end of the special-effects path.
- Takes the candidate pixels of BG0-3, OBJ and backdrop, plus BLDCNT/BLDALPHA/BLDY and the window effect-enable bit.
- Resolves the top two visible layers and decodes the blend mode.
- Emits the first/second RGB555 colours, a 2-bit control code, and the alpha/Y words consumed by three per-channel colour blenders.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/se_pkg.sv | 42 ++++
 rtl/se_layer_sort.sv | 72 +++++++
 rtl/se_target_select.sv | 161 ++++++++++++++++
 tb/tb_se_target_select.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/se_pkg.sv
// Shared definitions for the special-effects target-select front end:
// layer ids, blender control codes, BLDCNT field layout and the stage-1 record.
package se_pkg;

  localparam int SE_CW = 15;

  localparam logic [2:0] ID_BG0 = 3'd0;
  localparam logic [2:0] ID_BG1 = 3'd1;
  localparam logic [2:0] ID_BG2 = 3'd2;
  localparam logic [2:0] ID_BG3 = 3'd3;
  localparam logic [2:0] ID_OBJ = 3'd4;
  localparam logic [2:0] ID_BD  = 3'd5;

  localparam logic [1:0] CTRL_ALPHA  = 2'b00;
  localparam logic [1:0] CTRL_BRIGHT = 2'b10;
  localparam logic [1:0] CTRL_DARK   = 2'b11;

  localparam int BLD_T1_LSB   = 0;
  localparam int BLD_MODE_LSB = 6;
  localparam int BLD_T2_LSB   = 8;
  localparam int BLD_MASK_W   = 6;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_ALPHA  = 2'b01,
    MODE_BRIGHT = 2'b10,
    MODE_DARK   = 2'b11
  } bld_mode_e;

  typedef struct packed {
    logic [SE_CW-1:0] first_color;
    logic [SE_CW-1:0] second_color;
    logic [2:0]       top_id;
    logic [2:0]       second_id;
    logic             obj_semitrans;
    logic             win_effect_en;
    logic [15:0]      bldcnt;
    logic [15:0]      bldalpha;
    logic [15:0]      bldy;
  } s1_t;

endpackage

// File: rtl/se_layer_sort.sv
// Combinational top-two resolver over the opaque BG/OBJ candidates.
// Lower priority value wins; on ties OBJ beats every BG and lower BG index
// beats higher. Missing slots are filled with the backdrop.
module se_layer_sort
  import se_pkg::*;
#(
  parameter int NUM_BG = 4,
  parameter int CW     = 15
) (
  input  logic [NUM_BG*CW-1:0] bg_color,
  input  logic [NUM_BG-1:0]    bg_opaque,
  input  logic [NUM_BG*2-1:0]  bg_prio,
  input  logic [CW-1:0]        obj_color,
  input  logic                 obj_opaque,
  input  logic [1:0]           obj_prio,
  input  logic [CW-1:0]        backdrop,
  output logic [CW-1:0]        first_color,
  output logic [CW-1:0]        second_color,
  output logic [2:0]           first_id,
  output logic [2:0]           second_id
);

  localparam int NC = NUM_BG + 1;
  // Key {absent, prio, rank}: a plain unsigned compare gives the full ordering,
  // rank 0 is OBJ so it wins priority ties, then BG0, BG1, ...
  localparam logic [5:0] KEY_NONE = 6'b100000;

  logic [5:0]    cand_key [NC];
  logic [CW-1:0] cand_col [NC];
  logic [2:0]    cand_id  [NC];
  logic [5:0]    best_key;
  logic [5:0]    sec_key;

  // Build one sortable candidate per BG layer plus OBJ.
  always_comb begin
    for (int i = 0; i < NUM_BG; i++) begin
      cand_key[i] = bg_opaque[i] ? {1'b0, bg_prio[i*2 +: 2], 3'(i + 1)} : KEY_NONE;
      cand_col[i] = bg_color[i*CW +: CW];
      cand_id[i]  = 3'(i);
    end
    cand_key[NUM_BG] = obj_opaque ? {1'b0, obj_prio, 3'd0} : KEY_NONE;
    cand_col[NUM_BG] = obj_color;
    cand_id[NUM_BG]  = 3'(NUM_BG);
  end

  // Single pass keeping the best and runner-up; keys are unique so strict
  // compares are enough.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    best_key     = KEY_NONE;
    sec_key      = KEY_NONE;
    first_color  = backdrop;
    second_color = backdrop;
    first_id     = 3'(NUM_BG + 1);
    second_id    = 3'(NUM_BG + 1);
    for (int i = 0; i < NC; i++) begin
      if (cand_key[i] < best_key) begin
        sec_key      = best_key;
        second_color = first_color;
        second_id    = first_id;
        best_key     = cand_key[i];
        first_color  = cand_col[i];
        first_id     = cand_id[i];
      end else if (cand_key[i] < sec_key) begin
        sec_key      = cand_key[i];
        second_color = cand_col[i];
        second_id    = cand_id[i];
      end
    end
  end

endmodule

// File: rtl/se_target_select.sv
// Special-effects target select: stage 1 sorts the top two visible layers and
// captures the blend control words, stage 2 decodes the blender control code.
// Both stages advance together whenever the output slot is free or draining.
module se_target_select
  import se_pkg::*;
#(
  parameter int NUM_BG = 4,
  parameter int CW     = SE_CW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_BG*CW-1:0] bg_color,
  input  logic [NUM_BG-1:0]    bg_opaque,
  input  logic [NUM_BG*2-1:0]  bg_prio,
  input  logic [CW-1:0]        obj_color,
  input  logic                 obj_opaque,
  input  logic [1:0]           obj_prio,
  input  logic                 obj_semitrans,
  input  logic [CW-1:0]        backdrop,
  input  logic                 win_effect_en,
  input  logic [15:0]          bldcnt,
  input  logic [15:0]          bldalpha,
  input  logic [15:0]          bldy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        first_color,
  output logic [CW-1:0]        second_color,
  output logic [1:0]           control,
  output logic [15:0]          alpha_out,
  output logic [15:0]          y_out,
  output logic [2:0]           top_layer
);

  localparam logic [2:0] OBJ_ID = 3'(NUM_BG);

  logic          advance;
  logic          s1_valid;
  logic          s2_valid;
  s1_t           s1_q;
  logic [CW-1:0] srt_first_color;
  logic [CW-1:0] srt_second_color;
  logic [2:0]    srt_first_id;
  logic [2:0]    srt_second_id;

  logic [BLD_MASK_W-1:0] t1_mask;
  logic [BLD_MASK_W-1:0] t2_mask;
  bld_mode_e             mode;
  logic                  t1;
  logic                  t2;
  logic [1:0]            dec_control;
  logic [15:0]           dec_alpha;
  logic [15:0]           dec_y;
  logic                  unused_ctrl_bits;

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid;

  se_layer_sort #(
    .NUM_BG(NUM_BG),
    .CW    (CW)
  ) u_sort (
    .bg_color    (bg_color),
    .bg_opaque   (bg_opaque),
    .bg_prio     (bg_prio),
    .obj_color   (obj_color),
    .obj_opaque  (obj_opaque),
    .obj_prio    (obj_prio),
    .backdrop    (backdrop),
    .first_color (srt_first_color),
    .second_color(srt_second_color),
    .first_id    (srt_first_id),
    .second_id   (srt_second_id)
  );

  // Stage 1: capture the sorted pair together with the control words of this pixel.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.first_color   <= srt_first_color;
        s1_q.second_color  <= srt_second_color;
        s1_q.top_id        <= srt_first_id;
        s1_q.second_id     <= srt_second_id;
        s1_q.obj_semitrans <= obj_semitrans;
        s1_q.win_effect_en <= win_effect_en;
        s1_q.bldcnt        <= bldcnt;
        s1_q.bldalpha      <= bldalpha;
        s1_q.bldy          <= bldy;
      end
    end
  end

  // Stage 2 decode: semi-transparent OBJ over a second target forces alpha,
  // otherwise the window bit and BLDCNT mode select the effect.
  always_comb begin
    t1_mask     = s1_q.bldcnt[BLD_T1_LSB +: BLD_MASK_W];
    t2_mask     = s1_q.bldcnt[BLD_T2_LSB +: BLD_MASK_W];
    mode        = bld_mode_e'(s1_q.bldcnt[BLD_MODE_LSB +: 2]);
    t1          = t1_mask[s1_q.top_id];
    t2          = t2_mask[s1_q.second_id];
    dec_alpha   = {3'b000, s1_q.bldalpha[12:8], 3'b000, s1_q.bldalpha[4:0]};
    dec_control = CTRL_BRIGHT;
    dec_y       = '0;
    if (s1_q.top_id == OBJ_ID && s1_q.obj_semitrans && t2) begin
      dec_control = CTRL_ALPHA;
      dec_y       = {11'b0, s1_q.bldy[4:0]};
    end else if (s1_q.win_effect_en) begin
      unique case (mode)
        MODE_ALPHA: if (t1 && t2) begin
          dec_control = CTRL_ALPHA;
          dec_y       = {11'b0, s1_q.bldy[4:0]};
        end
        MODE_BRIGHT: if (t1) begin
          dec_control = CTRL_BRIGHT;
          dec_y       = {11'b0, s1_q.bldy[4:0]};
        end
        MODE_DARK: if (t1) begin
          dec_control = CTRL_DARK;
          dec_y       = {11'b0, s1_q.bldy[4:0]};
        end
        default: ;
      endcase
    end
  end

  // Stage 2 register: outputs only move when the downstream slot can take a new value.
  always_ff @(posedge clock) begin
    // NOTE: the output datapath is reset as well because its idle value is architecturally visible.
    if (reset) begin
      s2_valid     <= 1'b0;
      first_color  <= '0;
      second_color <= '0;
      control      <= CTRL_BRIGHT;
      alpha_out    <= '0;
      y_out        <= '0;
      top_layer    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        first_color  <= s1_q.first_color;
        second_color <= s1_q.second_color;
        control      <= dec_control;
        alpha_out    <= dec_alpha;
        y_out        <= dec_y;
        top_layer    <= s1_q.top_id;
      end
    end
  end

  // Register bits the blender never looks at.
  assign unused_ctrl_bits = ^{s1_q.bldcnt[15:14], s1_q.bldalpha[15:13],
                              s1_q.bldalpha[7:5], s1_q.bldy[15:5]};

endmodule

// File: tb/tb_se_target_select.sv
// Directed bench for se_target_select: vector table for the decode/sort cases,
// plus hand sequences for streaming with back-pressure and reset with both stages full.
module tb_se_target_select;

  localparam int NUM_BG = 4;
  localparam int CW     = 15;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_BG*CW-1:0] bg_color;
  logic [NUM_BG-1:0]    bg_opaque;
  logic [NUM_BG*2-1:0]  bg_prio;
  logic [CW-1:0]        obj_color;
  logic                 obj_opaque;
  logic [1:0]           obj_prio;
  logic                 obj_semitrans;
  logic [CW-1:0]        backdrop;
  logic                 win_effect_en;
  logic [15:0]          bldcnt;
  logic [15:0]          bldalpha;
  logic [15:0]          bldy;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        first_color;
  logic [CW-1:0]        second_color;
  logic [1:0]           control;
  logic [15:0]          alpha_out;
  logic [15:0]          y_out;
  logic [2:0]           top_layer;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  se_target_select #(.NUM_BG(NUM_BG), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bg_color     (bg_color),
    .bg_opaque    (bg_opaque),
    .bg_prio      (bg_prio),
    .obj_color    (obj_color),
    .obj_opaque   (obj_opaque),
    .obj_prio     (obj_prio),
    .obj_semitrans(obj_semitrans),
    .backdrop     (backdrop),
    .win_effect_en(win_effect_en),
    .bldcnt       (bldcnt),
    .bldalpha     (bldalpha),
    .bldy         (bldy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .first_color  (first_color),
    .second_color (second_color),
    .control      (control),
    .alpha_out    (alpha_out),
    .y_out        (y_out),
    .top_layer    (top_layer)
  );

  typedef struct {
    logic [59:0] bgc;
    logic [3:0]  bgo;
    logic [7:0]  bgp;
    logic [14:0] oc;
    logic        oo;
    logic [1:0]  op;
    logic        os;
    logic [14:0] bd;
    logic        win;
    logic [15:0] cnt;
    logic [15:0] alp;
    logic [15:0] ey;
    logic [14:0] e_first;
    logic [14:0] e_second;
    logic [1:0]  e_ctrl;
    logic [15:0] e_alpha;
    logic [15:0] e_y;
    logic [2:0]  e_top;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    bg_color      = '0;
    bg_opaque     = '0;
    bg_prio       = '0;
    obj_color     = '0;
    obj_opaque    = 1'b0;
    obj_prio      = '0;
    obj_semitrans = 1'b0;
    backdrop      = '0;
    win_effect_en = 1'b0;
    bldcnt        = '0;
    bldalpha      = '0;
    bldy          = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " control"},   32'(control),   32'h2);
    check({tag, " first"},     32'(first_color),  32'd0);
    check({tag, " second"},    32'(second_color), 32'd0);
    check({tag, " alpha"},     32'(alpha_out), 32'd0);
    check({tag, " y"},         32'(y_out),     32'd0);
    check({tag, " top"},       32'(top_layer), 32'd0);
  endtask

  initial begin
    int sent, rcv, waited;
    logic acc, dlv, held_valid;
    logic [14:0] held;

    //         bg_color {bg3,bg2,bg1,bg0}             bgo      bgp          oc       oo  op  os  bd        win cnt      alp      y        first    second   ctrl  alpha    y        top
    vecs[0] = '{{15'h0, 15'h0, 15'h7C00, 15'h001F}, 4'b0011, 8'b00000001, 15'h0,    0, 0, 0, 15'h7FFF, 1, 16'h0142, 16'h0808, 16'h0003, 15'h7C00, 15'h001F, 2'b00, 16'h0808, 16'h0003, 3'd1};
    vecs[1] = '{{15'h0, 15'h0155, 15'h0, 15'h0},   4'b0100, 8'b00100000, 15'h03E0, 1, 2, 1, 15'h0,    0, 16'h0400, 16'h1004, 16'h0000, 15'h03E0, 15'h0155, 2'b00, 16'h1004, 16'h0000, 3'd4};
    vecs[2] = '{{15'h0, 15'h0, 15'h0, 15'h0},      4'b0000, 8'b00000000, 15'h0,    0, 0, 0, 15'h1234, 1, 16'h00A0, 16'h0000, 16'h000C, 15'h1234, 15'h1234, 2'b10, 16'h0000, 16'h000C, 3'd5};
    vecs[3] = '{{15'h0ABC, 15'h0, 15'h0, 15'h0},   4'b1000, 8'b00000000, 15'h0,    0, 0, 0, 15'h1111, 1, 16'h00C1, 16'h1F1F, 16'h0007, 15'h0ABC, 15'h1111, 2'b10, 16'h1F1F, 16'h0000, 3'd3};
    vecs[4] = '{{15'h0, 15'h3333, 15'h0, 15'h0F0F}, 4'b0101, 8'b00110011, 15'h0,    0, 0, 0, 15'h2222, 1, 16'h00C1, 16'h0000, 16'h0010, 15'h0F0F, 15'h3333, 2'b11, 16'h0000, 16'h0010, 3'd0};
    vecs[5] = '{{15'h0, 15'h0, 15'h4444, 15'h0},   4'b0010, 8'b00001000, 15'h5555, 1, 2, 0, 15'h0,    0, 16'h0090, 16'h0000, 16'h0005, 15'h5555, 15'h4444, 2'b10, 16'h0000, 16'h0000, 3'd4};
    vecs[6] = '{{15'h0002, 15'h0, 15'h0, 15'h0},   4'b1000, 8'b01000000, 15'h0001, 1, 0, 1, 15'h0,    1, 16'h0190, 16'h0000, 16'h0009, 15'h0001, 15'h0002, 2'b10, 16'h0000, 16'h0009, 3'd4};
    vecs[7] = '{{15'h0, 15'h0, 15'h0200, 15'h0100}, 4'b0011, 8'b00001010, 15'h0,    0, 0, 0, 15'h0,    1, 16'h2041, 16'h0A05, 16'h0004, 15'h0100, 15'h0200, 2'b10, 16'h0A05, 16'h0000, 3'd0};
    vecs[8] = '{{15'h0, 15'h0, 15'h0, 15'h000A},   4'b0001, 8'b00000001, 15'h7000, 1, 1, 1, 15'h0,    1, 16'h01D0, 16'h0310, 16'h0014, 15'h7000, 15'h000A, 2'b00, 16'h0310, 16'h0014, 3'd4};

    idle_inputs();
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();

    // Table-driven single pixels.
    for (int v = 0; v < 9; v++) begin
      bg_color      = vecs[v].bgc;
      bg_opaque     = vecs[v].bgo;
      bg_prio       = vecs[v].bgp;
      obj_color     = vecs[v].oc;
      obj_opaque    = vecs[v].oo;
      obj_prio      = vecs[v].op;
      obj_semitrans = vecs[v].os;
      backdrop      = vecs[v].bd;
      win_effect_en = vecs[v].win;
      bldcnt        = vecs[v].cnt;
      bldalpha      = vecs[v].alp;
      bldy          = vecs[v].ey;
      in_valid      = 1'b1;
      tick();
      idle_inputs();
      check($sformatf("v%0d not valid after 1 clk", v), 32'(out_valid), 32'd0);
      tick();
      waited = 0;
      while (!out_valid && waited < 5) begin
        tick();
        waited++;
      end
      check($sformatf("v%0d latency", v), 32'(waited), 32'd0);
      check($sformatf("v%0d first", v),   32'(first_color),  32'(vecs[v].e_first));
      check($sformatf("v%0d second", v),  32'(second_color), 32'(vecs[v].e_second));
      check($sformatf("v%0d control", v), 32'(control),      32'(vecs[v].e_ctrl));
      check($sformatf("v%0d alpha", v),   32'(alpha_out),    32'(vecs[v].e_alpha));
      check($sformatf("v%0d y", v),       32'(y_out),        32'(vecs[v].e_y));
      check($sformatf("v%0d top", v),     32'(top_layer),    32'(vecs[v].e_top));
      tick();
      check($sformatf("v%0d single pulse", v), 32'(out_valid), 32'd0);
    end

    // Stream of 8 backdrop-only pixels with downstream stalled on cycles 3..5.
    sent = 0;
    rcv  = 0;
    held = '0;
    held_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      backdrop  = 15'(16'h0100 + 16'(sent));
      #1;
      if (out_valid && held_valid)
        check($sformatf("stream hold c%0d", cyc), 32'(first_color), 32'(held));
      if (out_valid && !out_ready)
        check($sformatf("stream in_ready c%0d", cyc), 32'(in_ready), 32'd0);
      if (out_valid && out_ready)
        check($sformatf("stream order %0d", rcv), 32'(first_color), 32'(16'h0100 + 16'(rcv)));
      acc        = in_valid && in_ready;
      dlv        = out_valid && out_ready;
      held_valid = out_valid && !out_ready;
      held       = first_color;
      tick();
      if (acc) sent++;
      if (dlv) rcv++;
    end
    idle_inputs();
    out_ready = 1'b1;
    check("stream count", 32'(rcv), 32'd8);
    tick();
    tick();
    check("stream no extra", 32'(out_valid), 32'd0);

    // Fill both stages under back-pressure, then reset.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    backdrop  = 15'h0ABC;
    bldcnt    = 16'h00A0;
    bldalpha  = 16'h1F1F;
    bldy      = 16'h0003;
    win_effect_en = 1'b1;
    tick();
    tick();
    check("fill out_valid", 32'(out_valid), 32'd1);
    check("fill in_ready", 32'(in_ready), 32'd0);
    check("fill y", 32'(y_out), 32'd3);
    reset = 1'b1;
    tick();
    idle_inputs();
    check_reset_state("mid rst");
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post rst quiet c%0d", c), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
